usb2_ep_in_packer: RTL and testbench



---
 rtl/usb2_ep_in_packer.sv | 122 ++++++++++++
 tb/tb_usb2_ep_in_packer.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb2_ep_in_packer.sv
// Byte stream to IN endpoint packet packer: fills the endpoint buffer, commits full/short packets.
// Optional zero-length packet after an s_last-terminated full packet: define USB2_PACKER_ZLP_EN.
module usb2_ep_in_packer #(
    parameter int unsigned MAX_PKT       = 512,
    parameter int unsigned FLUSH_TIMEOUT = 60000
) (
    input  logic        ext_clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [8:0]  buf_in_addr,
    output logic [7:0]  buf_in_data,
    output logic        buf_in_wren,
    input  logic        buf_in_ready,
    output logic        buf_in_commit,
    output logic [9:0]  buf_in_commit_len,
    input  logic        buf_in_commit_ack,
    output logic [15:0] stat_pkt_count,
    output logic        stat_busy
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
        COMMIT,
        RELEASE
    } state_t;

    localparam int unsigned   TW      = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST  = TW'((FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0);
    localparam logic [9:0]    PKT_LEN = 10'(MAX_PKT);
    localparam logic          T_EN    = (FLUSH_TIMEOUT != 0);

    state_t        state, state_nx;
    logic [9:0]    count;
    logic [TW-1:0] timer;
    logic          accept;
    logic          full_hit;
    logic          timeout_hit;
    logic          zlp_go;
    logic          fill_exit;

    assign accept      = (state == FILL) && s_valid;
    assign full_hit    = (count + 10'd1) == PKT_LEN;
    assign timeout_hit = T_EN && (state == FILL) && (count != 10'd0) && !s_valid && (timer == T_LAST);
    assign fill_exit   = (state == FILL) && (state_nx == DRAIN);

    assign s_ready       = (state == FILL);
    // Gated by reset so an aborted commit disappears in the reset cycle itself.
    assign buf_in_commit = (state == COMMIT) && !reset;
    assign stat_busy     = (state != IDLE);

`ifdef USB2_PACKER_ZLP_EN
    logic zlp_pending;

    always_ff @(posedge ext_clk) begin
        if (reset) begin
            zlp_pending <= 1'b0;
        end else if (fill_exit) begin
            zlp_pending <= accept && s_last && full_hit;
        end else if ((state == IDLE) && (state_nx == COMMIT)) begin
            zlp_pending <= 1'b0;
        end
    end

    assign zlp_go = zlp_pending;
`else
    assign zlp_go = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (buf_in_ready) state_nx = zlp_go ? COMMIT : FILL;
            FILL:    if ((accept && (full_hit || s_last)) || timeout_hit) state_nx = DRAIN;
            DRAIN:   state_nx = COMMIT;
            COMMIT:  if (buf_in_commit_ack) state_nx = RELEASE;
            RELEASE: if (!buf_in_commit_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ext_clk) begin
        if (reset) begin
            state             <= IDLE;
            count             <= '0;
            timer             <= '0;
            buf_in_addr       <= '0;
            buf_in_data       <= '0;
            buf_in_wren       <= 1'b0;
            buf_in_commit_len <= '0;
            stat_pkt_count    <= '0;
        end else begin
            state       <= state_nx;
            buf_in_wren <= accept;
            if (accept) begin
                buf_in_addr <= count[8:0];
                buf_in_data <= s_data;
                count       <= count + 10'd1;
            end
            if (fill_exit) begin
                buf_in_commit_len <= accept ? count + 10'd1 : count;
            end else if ((state == IDLE) && (state_nx == COMMIT)) begin
                buf_in_commit_len <= '0;
            end
            if ((state == COMMIT) && (state_nx == RELEASE)) begin
                count          <= '0;
                stat_pkt_count <= stat_pkt_count + 16'd1;
            end
            // Idle timer only counts while a partial packet is waiting for more bytes.
            if ((state == FILL) && (count != 10'd0) && !accept && !timeout_hit) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end
        end
    end

endmodule

// File: tb/tb_usb2_ep_in_packer.sv
// Scoreboard bench for usb2_ep_in_packer: expected writes/commit lengths queued at accept time.
module tb_usb2_ep_in_packer;

    localparam int unsigned MAX_PKT       = 512;
    localparam int unsigned FLUSH_TIMEOUT = 16;

    logic        ext_clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [8:0]  buf_in_addr;
    logic [7:0]  buf_in_data;
    logic        buf_in_wren;
    logic        buf_in_ready = 1'b0;
    logic        buf_in_commit;
    logic [9:0]  buf_in_commit_len;
    logic        buf_in_commit_ack;
    logic [15:0] stat_pkt_count;
    logic        stat_busy;

    always #5 ext_clk = ~ext_clk;

    usb2_ep_in_packer #(
        .MAX_PKT(MAX_PKT),
        .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
    ) dut (
        .ext_clk(ext_clk),
        .reset(reset),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_last(s_last),
        .s_ready(s_ready),
        .buf_in_addr(buf_in_addr),
        .buf_in_data(buf_in_data),
        .buf_in_wren(buf_in_wren),
        .buf_in_ready(buf_in_ready),
        .buf_in_commit(buf_in_commit),
        .buf_in_commit_len(buf_in_commit_len),
        .buf_in_commit_ack(buf_in_commit_ack),
        .stat_pkt_count(stat_pkt_count),
        .stat_busy(stat_busy)
    );

    int unsigned total = 0;
    int unsigned bad = 0;
    logic [16:0] wr_q[$];
    int unsigned len_q[$];
    int unsigned model_count = 0;
    int unsigned wr_seen = 0;
    int unsigned commit_seen = 0;
    int unsigned ack_delay = 0;
    bit          ack_en = 1'b1;
    bit          prev_commit = 1'b0;

    // Endpoint side: acknowledges each commit after ack_delay cycles.
    initial begin : ack_driver
        int unsigned n;
        n = 0;
        buf_in_commit_ack = 1'b0;
        forever begin
            @(negedge ext_clk);
            if (ack_en && buf_in_commit === 1'b1) begin
                if (n >= ack_delay) buf_in_commit_ack = 1'b1;
                else n++;
            end else if (buf_in_commit === 1'b0) begin
                buf_in_commit_ack = 1'b0;
                n = 0;
            end
        end
    end

    always @(negedge ext_clk) begin : monitor
        logic [16:0] exp_wr;
        int unsigned exp_len;
        if (buf_in_wren === 1'b1 && !reset) begin
            wr_seen++;
            total++;
            if (wr_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%0d data=%02h", buf_in_addr, buf_in_data);
            end else begin
                exp_wr = wr_q.pop_front();
                if ({buf_in_addr, buf_in_data} !== exp_wr) begin
                    bad++;
                    $display("FAIL write got addr=%0d data=%02h want addr=%0d data=%02h",
                             buf_in_addr, buf_in_data, exp_wr[16:8], exp_wr[7:0]);
                end
            end
        end
        if (buf_in_commit === 1'b1 && !prev_commit) begin
            commit_seen++;
            total++;
            if (len_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_commit len=%0d", buf_in_commit_len);
            end else begin
                exp_len = len_q.pop_front();
                if (buf_in_commit_len !== 10'(exp_len)) begin
                    bad++;
                    $display("FAIL commit_len got=%0d want=%0d", buf_in_commit_len, exp_len);
                end
            end
        end
        prev_commit = (buf_in_commit === 1'b1);
    end

    task automatic model_accept(input logic [7:0] d, input logic l);
        logic [8:0] a;
        a = 9'(model_count);
        wr_q.push_back({a, d});
        model_count++;
        if (l || model_count == MAX_PKT) begin
            len_q.push_back(model_count);
`ifdef USB2_PACKER_ZLP_EN
            if (l && model_count == MAX_PKT) len_q.push_back(0);
`endif
            model_count = 0;
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting posedge.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int unsigned n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (s_ready !== 1'b1 && n < 1000) begin
            @(negedge ext_clk);
            n++;
        end
        if (s_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL send_wait s_ready=%b want 1", s_ready);
        end else begin
            model_accept(d, l);
            @(negedge ext_clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_fill(input string tag);
        int unsigned n;
        n = 0;
        while (s_ready !== 1'b1 && n < 200) begin
            @(negedge ext_clk);
            n++;
        end
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_wait_fill s_ready=%b want 1", tag, s_ready);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        repeat (2) @(negedge ext_clk);
        reset = 1'b0;
        model_count = 0;
        wr_q.delete();
        len_q.delete();
    endtask

    task automatic test_reset;
        buf_in_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge ext_clk);
        total++;
        if ({s_ready, buf_in_wren, buf_in_commit, stat_busy} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000", {s_ready, buf_in_wren, buf_in_commit, stat_busy});
        end
        total++;
        if (buf_in_addr !== 9'd0 || buf_in_data !== 8'd0) begin
            bad++;
            $display("FAIL reset_wrbus addr=%0d data=%0d want 0", buf_in_addr, buf_in_data);
        end
        total++;
        if (buf_in_commit_len !== 10'd0 || stat_pkt_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_regs len=%0d pkts=%0d want 0", buf_in_commit_len, stat_pkt_count);
        end
        reset = 1'b0;
        @(negedge ext_clk);
        total++;
        if (stat_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy=%b want 0", stat_busy);
        end
    endtask

    task automatic test_full_packet;
        int unsigned w0, n;
        bit sr_bad, reached;
        ack_delay = 3;
        buf_in_ready = 1'b1;
        @(negedge ext_clk);
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_enter_fill s_ready=%b want 1", s_ready);
        end
        w0 = wr_seen;
        for (int i = 0; i < 512; i++) send_byte(8'(i), 1'b0);
        sr_bad = (s_ready !== 1'b0);
        reached = 1'b0;
        for (n = 0; n < 60; n++) begin
            @(negedge ext_clk);
            if (stat_busy === 1'b0) begin
                reached = 1'b1;
                break;
            end
            if (s_ready !== 1'b0) sr_bad = 1'b1;
        end
        total++;
        if (!reached || sr_bad) begin
            bad++;
            $display("FAIL full_sready_gap reached_idle=%b sready_seen=%b want 1/0", reached, sr_bad);
        end
        total++;
        if (stat_pkt_count !== 16'd1) begin
            bad++;
            $display("FAIL full_pkts got=%0d want=1", stat_pkt_count);
        end
        total++;
        if (wr_seen - w0 != 512) begin
            bad++;
            $display("FAIL full_writes got=%0d want=512", wr_seen - w0);
        end
        @(negedge ext_clk);
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_refill s_ready=%b want 1", s_ready);
        end
    endtask

    task automatic test_last;
        ack_delay = 0;
        for (int i = 0; i < 9; i++) send_byte(8'hA0 + 8'(i), 1'b0);
        send_byte(8'hA9, 1'b1);
        total++;
        if (buf_in_commit !== 1'b0 || s_ready !== 1'b0) begin
            bad++;
            $display("FAIL last_drain commit=%b s_ready=%b want 0/0", buf_in_commit, s_ready);
        end
        @(negedge ext_clk);
        total++;
        if (buf_in_commit !== 1'b1) begin
            bad++;
            $display("FAIL last_commit_latency commit=%b want 1", buf_in_commit);
        end
        wait_fill("last");
        for (int i = 0; i < 3; i++) send_byte(8'h50 + 8'(i), (i == 2));
        wait_fill("last2");
        total++;
        if (stat_pkt_count !== 16'd3) begin
            bad++;
            $display("FAIL last_pkts got=%0d want=3", stat_pkt_count);
        end
    endtask

    task automatic test_timeout;
        int unsigned n;
        bit bad_empty;
        for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), 1'b0);
        len_q.push_back(model_count);
        model_count = 0;
        for (n = 1; n <= 40; n++) begin
            @(negedge ext_clk);
            if (buf_in_commit === 1'b1) break;
        end
        total++;
        if (n != 17) begin
            bad++;
            $display("FAIL timeout_latency got=%0d want=17", n);
        end
        wait_fill("timeout");
        bad_empty = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ext_clk);
            if (buf_in_commit !== 1'b0 || s_ready !== 1'b1) bad_empty = 1'b1;
        end
        total++;
        if (bad_empty || stat_pkt_count !== 16'd4) begin
            bad++;
            $display("FAIL timeout_empty moved=%b pkts=%0d want 0/4", bad_empty, stat_pkt_count);
        end
    endtask

    task automatic test_not_ready;
        bit moved;
        buf_in_ready = 1'b0;
        do_reset();
        s_valid = 1'b1;
        s_data = 8'h77;
        moved = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ext_clk);
            if (s_ready !== 1'b0 || buf_in_wren !== 1'b0 || stat_busy !== 1'b0) moved = 1'b1;
        end
        total++;
        if (moved) begin
            bad++;
            $display("FAIL notready_hold activity=1 want 0");
        end
        s_valid = 1'b0;
        buf_in_ready = 1'b1;
        @(negedge ext_clk);
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL notready_release s_ready=%b want 1", s_ready);
        end
    endtask

    task automatic test_reset_commit;
        int unsigned n;
        ack_en = 1'b0;
        for (int i = 0; i < 199; i++) send_byte(8'(i * 3), 1'b0);
        send_byte(8'hEE, 1'b1);
        n = 0;
        while (buf_in_commit !== 1'b1 && n < 10) begin
            @(negedge ext_clk);
            n++;
        end
        total++;
        if (buf_in_commit !== 1'b1 || buf_in_commit_len !== 10'd200) begin
            bad++;
            $display("FAIL rstc_commit commit=%b len=%0d want 1/200", buf_in_commit, buf_in_commit_len);
        end
        repeat (3) @(negedge ext_clk);
        reset = 1'b1;
        #1;
        total++;
        if (buf_in_commit !== 1'b0) begin
            bad++;
            $display("FAIL rstc_drop commit=%b want 0", buf_in_commit);
        end
        @(negedge ext_clk);
        @(negedge ext_clk);
        reset = 1'b0;
        model_count = 0;
        wr_q.delete();
        len_q.delete();
        ack_en = 1'b1;
        total++;
        if (stat_pkt_count !== 16'd0) begin
            bad++;
            $display("FAIL rstc_pkts got=%0d want=0", stat_pkt_count);
        end
        wait_fill("rstc");
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), (i == 4));
        wait_fill("rstc2");
        total++;
        if (stat_pkt_count !== 16'd1) begin
            bad++;
            $display("FAIL rstc_next_pkts got=%0d want=1", stat_pkt_count);
        end
    endtask

    task automatic test_zlp;
        int unsigned c0, n;
        int unsigned exp_pkts, exp_commits;
`ifdef USB2_PACKER_ZLP_EN
        exp_commits = 2;
`else
        exp_commits = 1;
`endif
        exp_pkts = 32'(stat_pkt_count) + exp_commits;
        ack_delay = 1;
        c0 = commit_seen;
        for (int i = 0; i < 512; i++) send_byte(8'(255 - i), (i == 511));
        n = 0;
        while (!(s_ready === 1'b1 && stat_pkt_count == 16'(exp_pkts)) && n < 100) begin
            @(negedge ext_clk);
            n++;
        end
        total++;
        if (stat_pkt_count !== 16'(exp_pkts)) begin
            bad++;
            $display("FAIL zlp_pkts got=%0d want=%0d", stat_pkt_count, exp_pkts);
        end
        repeat (5) @(negedge ext_clk);
        total++;
        if (commit_seen - c0 != exp_commits) begin
            bad++;
            $display("FAIL zlp_commits got=%0d want=%0d", commit_seen - c0, exp_commits);
        end
    endtask

    initial begin
        test_reset();
        test_full_packet();
        test_last();
        test_timeout();
        test_not_ready();
        test_reset_commit();
        test_zlp();
        total++;
        if (wr_q.size() != 0 || len_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover writes=%0d commits=%0d want 0/0", wr_q.size(), len_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
